// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the 5-stage MIPS pipeline.
// It drives the PC register enable and the enables and flushes of the
// Fetch->Decode and Decode->Execute pipeline registers.
//   - A load-use hazard inserts a one-cycle bubble into EX and freezes PC and FD.
//   - A taken branch or jump squashes the instruction that was just fetched.
//   - A multi-cycle mult/div freezes the front of the pipe for DIV_CYCLES cycles.
//
// Parameters:
//   DIV_CYCLES  total EX occupancy of a mult/div instruction (2..255)
//   STAT_W      width of the stall statistics counter
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   id_rs/id_rt       source register fields of the instruction in ID
//   id_use_rs/rt      the ID instruction really reads rs / rt
//   ex_mem_read       the instruction in EX is a load
//   ex_rd             destination register of the instruction in EX
//   id_branch_taken   branch or jump resolved taken in ID this cycle
//   ex_div_start      mult/div present in EX (looked at only in IDLE)
//   pc_en, fd_en      PC and FD register load enables
//   fd_flush          load a NOP into FD
//   de_flush          load a bubble into DE
//   ex_hold           hold DE and the EX-stage state
//   div_busy          controller is in DIV_WAIT
//   stall_cnt         number of front-end stall cycles (pc_en low)
//
// Optional feature: define HAZARD_STATS_EN to build the saturating stall
// counter. When it is not defined, stall_cnt is tied to zero and no flops are built.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              id_branch_taken,
  input  logic              ex_div_start,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              ex_hold,
  output logic              div_busy,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, DIV_WAIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;

  // A load to $0 never creates a hazard, because $0 is hard-wired.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    ex_hold   = 1'b0;
    div_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_div_start) begin
          // The start cycle is the first hold cycle. DIV_WAIT then covers
          // the remaining DIV_CYCLES-1 cycles, counting cnt down to 0.
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          ex_hold   = 1'b1;
          state_nxt = DIV_WAIT;
          cnt_nxt   = 8'(DIV_CYCLES - 2);
        end else if (load_use) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
        end else if (id_branch_taken) begin
          fd_flush = 1'b1;
        end
      end
      DIV_WAIT: begin
        // ID is frozen, so hazards and branches are evaluated again after release.
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        ex_hold  = 1'b1;
        div_busy = 1'b1;
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is asserted, force every output low whatever the inputs are.
    if (rst) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      ex_hold  = 1'b0;
      div_busy = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (!pc_en && (stall_q != '1))
      stall_q <= stall_q + STAT_W'(1);
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS dynamic pipeline. Sits beside the Fetch→Decode and Decode→Execute pipeline registers and the PC register, and drives their enables and flushes. Resolves load-use hazards with a one-cycle bubble, squashes the fetched instruction on taken branches/jumps, and freezes the front of the pipe while a multi-cycle mult/div occupies EX.

## Interface

Parameters:
- DIV_CYCLES, 8, total EX occupancy of a mult/div instruction in cycles; legal range 2..255
- STAT_W, 16, width of stall statistics counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of instruction in EX
- id_branch_taken  in  1  branch/jump resolved taken in ID this cycle
- ex_div_start  in  1  mult/div instruction present in EX; sampled only in IDLE
- pc_en  out  1  PC register update enable
- fd_en  out  1  Fetch→Decode register load enable
- fd_flush  out  1  load NOP (32'h0) into Fetch→Decode register
- de_flush  out  1  load bubble into Decode→Execute register
- ex_hold  out  1  hold Decode→Execute register and EX-stage state
- div_busy  out  1  controller is in DIV_WAIT
- stall_cnt  out  STAT_W  count of front-end stall cycles (see Configuration)

## Operation

- States: IDLE, DIV_WAIT. Down-counter cnt, 8 bits.
- load_use = ex_mem_read && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).
- Priority per cycle: reset > div hold > load-use > branch flush > normal.
- Div hold (IDLE with ex_div_start=1, or any DIV_WAIT cycle): pc_en=0, fd_en=0, ex_hold=1, fd_flush=0, de_flush=0; load_use and id_branch_taken ignored (ID frozen, re-evaluated after release).
- IDLE + ex_div_start: next state DIV_WAIT, cnt <= DIV_CYCLES-2.
- DIV_WAIT: cnt decrements each cycle; when cnt == 0, next state IDLE. ex_div_start ignored.
- Load-use (IDLE, no div): pc_en=0, fd_en=0, de_flush=1, fd_flush=0. Single cycle; bubble clears ex_mem_read next cycle.
- Branch (IDLE, no div, no load_use, id_branch_taken=1): pc_en=1, fd_en=1, fd_flush=1 (fd_flush overrides fd_en in the register).
- Load-use and branch together: load-use wins; branch re-resolved next cycle with forwarded data.
- Normal: pc_en=1, fd_en=1, all others 0.
- div_busy = (state == DIV_WAIT).

## Timing

- All outputs except div_busy and stall_cnt are combinational from state and inputs; no added latency.
- Reset value (rst=1, forced regardless of inputs): state=IDLE, cnt=0, pc_en=0, fd_en=0, fd_flush=0, de_flush=0, ex_hold=0, div_busy=0, stall_cnt=0.
- Div hold lasts exactly DIV_CYCLES consecutive cycles starting with the ex_div_start cycle; pipe advances on the next edge. DIV_CYCLES=2 gives one DIV_WAIT cycle.
- A new ex_div_start on the release cycle's following IDLE cycle starts a fresh hold (back-to-back divs).
- rst asserted mid-DIV_WAIT aborts the division: IDLE immediately, outputs to reset values.

## Configuration

- HAZARD_STATS_EN defined: stall_cnt increments on every posedge with rst=0 and pc_en=0; saturates at all-ones; cleared by rst.
- Undefined: no counter flops; stall_cnt tied to 0.

## Test plan

- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_use_rs=1 → one cycle pc_en=0, fd_en=0, de_flush=1; next cycle normal.
- Load to $0: ex_rd=0, id_rs=0, id_use_rs=1 → no stall, pc_en=1.
- Taken branch, no hazard → fd_flush=1, pc_en=1 for one cycle; with simultaneous load-use → de_flush=1, fd_flush=0.
- Div, DIV_CYCLES=8: ex_div_start pulse → ex_hold=1, pc_en=0 for exactly 8 cycles, div_busy=1 for 7; branch/load-use inputs ignored throughout.
- Reset mid-div at cycle 3 → all outputs 0 immediately; after release, state IDLE, pc_en=1.
- With HAZARD_STATS_EN: one load-use plus one 8-cycle div → stall_cnt=9; STAT_W=2 with 5 stall cycles → stall_cnt=3.
